seq_multiplier: RTL and testbench

//  Parametrised iterative shift-add multiplier; successor of the fixed 4-bit unsigned unit.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_step.sv | 40 ++++
 rtl/seq_multiplier.sv | 123 ++++++++++++
 tb/tb_seq_multiplier.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  // Control states of the multiplier sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a step counter that must be able to hold the value n.
  function automatic int step_count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration of the multiplier datapath (purely combinational).
// The low bit of the working product selects whether the multiplicand is
// added into the upper half. In signed mode the final step (the multiplier
// sign bit) subtracts instead. The N+1-bit sum is then shifted right together
// with the lower half.
module mult_step
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [2*N-1:0] product,
  input  logic [N-1:0]   multiplicand,
  input  logic           is_signed,
  input  logic           last_step,
  output logic [2*N-1:0] next_product
);

  logic [N:0]   upper_ext;
  logic [N:0]   mcand_ext;
  logic [N:0]   sum;
  logic [2*N:0] joined;

  // Extend both operands by one bit, conditionally add or subtract, then shift right.
  always_comb begin
    upper_ext = {is_signed & product[2*N-1], product[2*N-1:N]};
    mcand_ext = {is_signed & multiplicand[N-1], multiplicand};
    sum       = upper_ext;
    if (product[0]) begin
      if (is_signed && last_step) begin
        sum = upper_ext - mcand_ext;
      end else begin
        sum = upper_ext + mcand_ext;
      end
    end
    // The sum's top bit carries the carry (unsigned) or the sign (signed).
    joined       = {sum, product[N-1:0]};
    next_product = joined[2*N:1];
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative N x N -> 2N shift-add multiplier, one multiplier bit per clock.
// Supports signed and unsigned operation. A start request is ignored while busy.
// The optional macro MULT_EARLY_EXIT_EN lets unsigned operations finish as soon
// as the remaining multiplier bits are all zero.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           ready,
  output logic           done
);

  localparam int CW = step_count_width(N);
  localparam logic [CW-1:0] COUNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] COUNT_MAX  = CW'(N);

  state_t         state_q, state_d;
  logic [2*N-1:0] product_q, product_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic           signed_q, signed_d;
  logic [CW-1:0]  count_q, count_d;
  logic           done_q, done_d;
  logic [2*N-1:0] step_product;

  mult_step #(.N(N)) u_step (
    .product      (product_q),
    .multiplicand (mcand_q),
    .is_signed    (signed_q),
    .last_step    (count_q == COUNT_LAST),
    .next_product (step_product)
  );

`ifdef MULT_EARLY_EXIT_EN
  logic rest_zero;
  int   remaining;

  // Detect when every multiplier bit that has not yet been retired is zero.
  always_comb begin
    remaining = N - int'(count_q);
    rest_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i < remaining && product_q[i]) begin
        rest_zero = 1'b0;
      end
    end
  end
`endif

  // Register all state; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      product_q <= '0;
      mcand_q   <= '0;
      signed_q  <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
      mcand_q   <= mcand_d;
      signed_q  <= signed_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: accept in IDLE/DONE, iterate in RUN, finish after N steps.
  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    mcand_d   = mcand_q;
    signed_d  = signed_q;
    count_d   = count_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          product_d = {{N{1'b0}}, multiplier};
          mcand_d   = multiplicand;
          signed_d  = is_signed;
          count_d   = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
`ifdef MULT_EARLY_EXIT_EN
        if (!signed_q && rest_zero) begin
          // Remaining steps would only shift; apply them all at once.
          product_d = product_q >> remaining;
          count_d   = COUNT_MAX;
          state_d   = DONE;
          done_d    = 1'b1;
        end else
`endif
        begin
          product_d = step_product;
          count_d   = count_q + CW'(1);
          if (count_q == COUNT_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;
  assign busy    = (state_q == RUN);
  assign ready   = (state_q == DONE);
  assign done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at N=4 and N=8. Results are compared
// against plain integer multiplication. Set MULT_EARLY_EXIT_EN to match the DUT build.
module tb_seq_multiplier;

  logic        clock;
  logic        reset_n;
  logic        start4, sgn4, start8, sgn8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic        busy4, ready4, done4, busy8, ready8, done8;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.N(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .is_signed(sgn4),
    .multiplicand(a4), .multiplier(b4), .product(prod4),
    .busy(busy4), .ready(ready4), .done(done4)
  );

  seq_multiplier #(.N(8)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .is_signed(sgn8),
    .multiplicand(a8), .multiplier(b8), .product(prod8),
    .busy(busy8), .ready(ready8), .done(done8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input bit w8, output logic [15:0] p, output logic bsy,
                        output logic rdy, output logic dn);
    if (w8) begin p = prod8; bsy = busy8; rdy = ready8; dn = done8; end
    else    begin p = {8'h00, prod4}; bsy = busy4; rdy = ready4; dn = done4; end
  endtask

  task automatic drive(input bit w8, input logic st, input logic [7:0] a,
                       input logic [7:0] b, input logic sg);
    if (w8) begin start8 = st; a8 = a; b8 = b; sgn8 = sg; end
    else    begin start4 = st; a4 = a[3:0]; b4 = b[3:0]; sgn4 = sg; end
  endtask

  // Reference product: ordinary integer multiply, reduced mod 2^(2n).
  function automatic logic [15:0] ref_prod(input bit w8, input logic [7:0] a,
                                           input logic [7:0] b, input bit sgn);
    longint sa, sb, p;
    int n = w8 ? 8 : 4;
    if (sgn) begin
      sa = w8 ? longint'($signed(a)) : longint'($signed(a[3:0]));
      sb = w8 ? longint'($signed(b)) : longint'($signed(b[3:0]));
    end else begin
      sa = w8 ? longint'(a) : longint'(a[3:0]);
      sb = w8 ? longint'(b) : longint'(b[3:0]);
    end
    p = sa * sb;
    return 16'(p & ((longint'(1) << (2 * n)) - 1));
  endfunction

  // Expected number of edges from accept to ready.
  function automatic int ref_lat(input bit w8, input logic [7:0] b, input bit sgn);
    int n = w8 ? 8 : 4;
`ifdef MULT_EARLY_EXIT_EN
    int bl = 0;
    if (!sgn) begin
      for (int i = 0; i < n; i++) if (b[i]) bl = i + 1;
      return (bl + 1 < n) ? bl + 1 : n;
    end
`endif
    return n;
  endfunction

  // One full operation: accept, wait (bounded) for ready, check result and pulse.
  task automatic do_op(input string tag, input bit w8, input logic [7:0] a,
                       input logic [7:0] b, input bit sgn, input bit hold,
                       input logic [15:0] exp_p, input int exp_lat);
    logic [15:0] p, bmask;
    logic bsy, rdy, dn;
    int n = w8 ? 8 : 4;
    int lat = 0;
    bmask = w8 ? {8'h00, b} : {12'h000, b[3:0]};
    @(negedge clock);
    drive(w8, 1'b1, a, b, sgn);
    @(posedge clock); #1;
    if (hold) drive(w8, 1'b1, ~a, ~b, ~sgn);
    else      drive(w8, 1'b0, a, b, sgn);
    sample(w8, p, bsy, rdy, dn);
    check({tag, "_accept_prod"}, p, bmask);
    check({tag, "_accept_busy"}, bsy, 1'b1);
    check({tag, "_accept_ready"}, rdy, 1'b0);
    for (int i = 1; i <= n + 2; i++) begin
      @(posedge clock); #1;
      sample(w8, p, bsy, rdy, dn);
      lat = i;
      if (rdy) break;
      check({tag, "_step_done_low"}, dn, 1'b0);
    end
    drive(w8, 1'b0, a, b, sgn);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_prod"}, p, exp_p);
    check({tag, "_done_pulse"}, dn, 1'b1);
    check({tag, "_busy_clear"}, bsy, 1'b0);
    @(posedge clock); #1;
    sample(w8, p, bsy, rdy, dn);
    check({tag, "_done_one_cycle"}, dn, 1'b0);
    check({tag, "_ready_hold"}, rdy, 1'b1);
    check({tag, "_prod_hold"}, p, exp_p);
    $display("op %s w8=%0d a=%0h b=%0h sgn=%0d prod=%0h exp=%0h lat=%0d", tag, w8, a, b, sgn, p, exp_p, lat);
  endtask

  initial begin
    logic [15:0] p;
    logic bsy, rdy, dn;
    logic [7:0] steps [4];
    logic [7:0] ra, rb;
    bit rw8, rsg;
    steps[0] = 8'd3; steps[1] = 8'd89; steps[2] = 8'd132; steps[3] = 8'd66;

    // Reset held, then released with no start.
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(1'b1, 1'b0, 8'h0, 8'h0, 1'b0);
    repeat (2) @(negedge clock);
    check("rst_prod4", prod4, 8'h00);
    check("rst_busy4", busy4, 1'b0);
    check("rst_ready4", ready4, 1'b0);
    check("rst_done4", done4, 1'b0);
    check("rst_prod8", prod8, 16'h0000);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_prod4", prod4, 8'h00);
    check("idle_busy4", busy4, 1'b0);
    check("idle_ready4", ready4, 1'b0);
    check("idle_done4", done4, 1'b0);
    $display("reset checks done");

    // Unsigned 11*6 with every intermediate product.
    @(negedge clock);
    drive(1'b0, 1'b1, 8'd11, 8'd6, 1'b0);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 8'd11, 8'd6, 1'b0);
    check("u11x6_accept", prod4, 8'd6);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("u11x6_step_prod", prod4, steps[i]);
      check("u11x6_step_ready", ready4, (i == 3));
      check("u11x6_step_done", done4, (i == 3));
    end
    @(posedge clock); #1;
    check("u11x6_ready_hold", ready4, 1'b1);
    check("u11x6_done_low", done4, 1'b0);
    check("u11x6_prod_hold", prod4, 8'd66);
    $display("op u11x6 prod=%0d", prod4);

    // Directed signed/unsigned corner cases.
    do_op("s_m5x6", 1'b0, 8'h0B, 8'h06, 1'b1, 1'b0, 16'h00E2, 4);
    do_op("s_m5xm2", 1'b0, 8'h0B, 8'h0E, 1'b1, 1'b0, 16'h000A, 4);
    do_op("u15x15", 1'b0, 8'h0F, 8'h0F, 1'b0, 1'b0, 16'd225, 4);

    // start held high through RUN with scrambled operands: ignored.
    do_op("hold_start", 1'b0, 8'd11, 8'd6, 1'b0, 1'b1, 16'd66, 4);

    // Asynchronous reset after step 2.
    @(negedge clock);
    drive(1'b0, 1'b1, 8'd11, 8'd6, 1'b0);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 8'd11, 8'd6, 1'b0);
    repeat (2) @(posedge clock);
    #2;
    check("midrst_pre_prod", prod4, 8'd89);
    reset_n = 1'b0;
    #1;
    check("midrst_prod", prod4, 8'h00);
    check("midrst_busy", busy4, 1'b0);
    check("midrst_ready", ready4, 1'b0);
    check("midrst_done", done4, 1'b0);
    $display("async reset mid-operation prod=%0h", prod4);
    @(negedge clock);
    reset_n = 1'b1;
    do_op("after_rst", 1'b0, 8'd11, 8'd6, 1'b0, 1'b0, 16'd66, 4);

    // N=8 corner cases.
    do_op("u200x200", 1'b1, 8'd200, 8'd200, 1'b0, 1'b0, 16'h9C40, 8);
    do_op("s80x80", 1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 8);

    // Small multiplier: latency depends on early-exit build.
`ifdef MULT_EARLY_EXIT_EN
    do_op("u11x1", 1'b0, 8'd11, 8'd1, 1'b0, 1'b0, 16'd11, 2);
`else
    do_op("u11x1", 1'b0, 8'd11, 8'd1, 1'b0, 1'b0, 16'd11, 4);
`endif
    do_op("s11x1", 1'b0, 8'd11, 8'd1, 1'b1, 1'b0, 16'h00FB, 4);

    // Back-to-back restart from DONE, then randomized operations.
    for (int it = 0; it < 24; it++) begin
      rw8 = 1'($urandom_range(0, 1));
      rsg = 1'($urandom_range(0, 1));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (it % 4 == 0) rb = rb & 8'h03;
      do_op("rand", rw8, ra, rb, rsg, 1'b0, ref_prod(rw8, ra, rb, rsg), ref_lat(rw8, rb, rsg));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
